// File: rtl/exe_stage.sv
// Execute stage of the 16-bit RSA ASIP pipeline.
// Performs one ALU operation per cycle: add, compare/subtract, modular multiply or move.
// Also resolves jumps/branches and forwards the jump target.
// Every output is registered, so results appear one cycle after the operands are sampled.
module exe_stage #(
  parameter int unsigned ARQ = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_mux_exe,
  input  logic           i_jop_lsb,
  input  logic           i_jenable,
  input  logic [1:0]     i_alu_op,
  input  logic [ARQ-1:0] i_src1,
  input  logic [ARQ-1:0] i_src2,
  input  logic [ARQ-1:0] i_srcdest,
  input  logic [ARQ-1:0] i_imm,
  input  logic [12:0]    i_jaddr,
  output logic [ARQ-1:0] o_alu_result,
  output logic           o_branch_taken,
  output logic [12:0]    o_jaddr_out
);

  localparam int unsigned JW = 13;
  localparam int unsigned PW = 2 * ARQ;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  logic [ARQ-1:0] w_opb;
  logic [PW-1:0]  w_prod;
  logic [PW-1:0]  w_mod;
  logic           w_eq;
  logic           w_cond;
  logic [ARQ-1:0] w_alu_next;
  logic           w_branch_next;

  // Operand select, full-width product with reduction, and branch condition
  always_comb begin
    w_opb  = i_mux_exe ? i_imm : i_src2;
    w_prod = PW'(i_src1) * PW'(w_opb);
    w_mod  = '0;
    if (i_srcdest != '0) begin
      w_mod = w_prod % PW'(i_srcdest);
    end
    w_eq   = (i_src1 == i_src2);
    w_cond = i_jop_lsb ? w_eq : !w_eq;
  end

  // ALU result and branch decision for the current opcode
  always_comb begin
    w_alu_next    = '0;
    w_branch_next = i_jenable;
    case (i_alu_op)
      OP_ADD: w_alu_next = i_src1 + w_opb;
      OP_CMP: begin
        // Compare always uses the register operand, never the immediate
        w_alu_next    = i_src1 - i_src2;
        w_branch_next = i_jenable | w_cond;
      end
      OP_MUL: w_alu_next = ARQ'(w_mod);
      OP_MOV: w_alu_next = w_opb;
      default: w_alu_next = '0;
    endcase
  end

  // Output registers; synchronous reset overrides any operation in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_alu_result   <= '0;
      o_branch_taken <= 1'b0;
      o_jaddr_out    <= '0;
    end else begin
      o_alu_result   <= w_alu_next;
      o_branch_taken <= w_branch_next;
      o_jaddr_out    <= JW'(i_jaddr);
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: hand-computed expectations queued at drive time,
// popped and compared one cycle later.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mux_exe;
  logic        jop_lsb;
  logic        jenable;
  logic [1:0]  alu_op;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [15:0] srcdest;
  logic [15:0] imm;
  logic [12:0] jaddr;
  logic [15:0] alu_result;
  logic        branch_taken;
  logic [12:0] jaddr_out;

  typedef struct {
    string       tag;
    logic [15:0] alu;
    logic        br;
    logic [12:0] ja;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  exe_stage #(.ARQ(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mux_exe      (mux_exe),
    .i_jop_lsb      (jop_lsb),
    .i_jenable      (jenable),
    .i_alu_op       (alu_op),
    .i_src1         (src1),
    .i_src2         (src2),
    .i_srcdest      (srcdest),
    .i_imm          (imm),
    .i_jaddr        (jaddr),
    .o_alu_result   (alu_result),
    .o_branch_taken (branch_taken),
    .o_jaddr_out    (jaddr_out)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs and queue what the DUT must show after the next edge
  task automatic drive(input string tag, input logic r, input logic mx, input logic jl,
                       input logic je, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] m, input logic [15:0] im,
                       input logic [12:0] ja, input logic [15:0] e_alu, input logic e_br,
                       input logic [12:0] e_ja);
    exp_t e;
    rst = r; mux_exe = mx; jop_lsb = jl; jenable = je; alu_op = op;
    src1 = a; src2 = b; srcdest = m; imm = im; jaddr = ja;
    e.tag = tag; e.alu = e_alu; e.br = e_br; e.ja = e_ja;
    q.push_back(e);
  endtask

  // Advance one edge, then pop the oldest expectation and compare all outputs
  task automatic check();
    exp_t e;
    @(posedge clk);
    #1;
    n_tests++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      assert (alu_result === e.alu) else begin
        n_fail++;
        $error("FAIL %s alu_result observed=%h expected=%h", e.tag, alu_result, e.alu);
      end
      n_tests++;
      assert (branch_taken === e.br) else begin
        n_fail++;
        $error("FAIL %s branch_taken observed=%b expected=%b", e.tag, branch_taken, e.br);
      end
      n_tests++;
      assert (jaddr_out === e.ja) else begin
        n_fail++;
        $error("FAIL %s jaddr_out observed=%0d expected=%0d", e.tag, jaddr_out, e.ja);
      end
    end
  endtask

  initial begin
    // Reset held for two edges, outputs must stay at zero
    drive("reset0", 1, 0, 0, 0, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 13'd1500, 16'd0, 0, 13'd0);
    check();
    drive("reset1", 1, 0, 0, 0, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 13'd1500, 16'd0, 0, 13'd0);
    check();
    // ADD with immediate
    drive("add_imm", 0, 1, 1, 0, 2'b00, 16'd250, 16'd0, 16'd0, 16'd400, 13'd1500, 16'd650, 0, 13'd1500);
    check();
    // Compare equal, branch-if-equal; immediate must be ignored
    drive("cmp_eq", 0, 1, 1, 0, 2'b01, 16'd250, 16'd250, 16'd0, 16'd25, 13'd1500, 16'd0, 1, 13'd1500);
    check();
    // Compare unequal, branch-if-equal then branch-if-not-equal
    drive("cmp_ne_jeq", 0, 1, 1, 0, 2'b01, 16'd250, 16'd251, 16'd0, 16'd25, 13'd1500, 16'hFFFF, 0, 13'd1500);
    check();
    drive("cmp_ne_jne", 0, 1, 0, 0, 2'b01, 16'd250, 16'd251, 16'd0, 16'd25, 13'd1500, 16'hFFFF, 1, 13'd1500);
    check();
    // Compare where imm equals src1 but src2 does not: 10-3=7, not equal
    drive("cmp_mux_ign", 0, 1, 1, 0, 2'b01, 16'd10, 16'd3, 16'd0, 16'd10, 13'd1500, 16'd7, 0, 13'd1500);
    check();
    // MODMUL 6*1927 mod 1349 = 770, then reset over it, then recovery
    drive("modmul", 0, 0, 0, 0, 2'b10, 16'd6, 16'd1927, 16'd1349, 16'd0, 13'd1500, 16'd770, 0, 13'd1500);
    check();
    drive("modmul_rst", 1, 0, 0, 0, 2'b10, 16'd6, 16'd1927, 16'd1349, 16'd0, 13'd1500, 16'd0, 0, 13'd0);
    check();
    drive("modmul_rec", 0, 0, 0, 0, 2'b10, 16'd6, 16'd1927, 16'd1349, 16'd0, 13'd1500, 16'd770, 0, 13'd1500);
    check();
    // Unconditional jump with ADD 6+1927, max jump address
    drive("jump", 0, 0, 0, 1, 2'b00, 16'd6, 16'd1927, 16'd0, 16'd0, 13'd8191, 16'd1933, 1, 13'd8191);
    check();
    // Reset dominates a jump request
    drive("jump_rst", 1, 0, 0, 1, 2'b00, 16'd6, 16'd1927, 16'd0, 16'd0, 13'd8191, 16'd0, 0, 13'd0);
    check();
    // MOVE immediate
    drive("move", 0, 1, 0, 0, 2'b11, 16'd7, 16'd9, 16'd0, 16'h1234, 13'd8191, 16'h1234, 0, 13'd8191);
    check();
    // MOVE register operand
    drive("move_reg", 0, 0, 0, 0, 2'b11, 16'd7, 16'hBEEF, 16'd0, 16'h1234, 13'd42, 16'hBEEF, 0, 13'd42);
    check();
    // MODMUL by zero modulus yields zero
    drive("modmul_m0", 0, 0, 0, 0, 2'b10, 16'd6, 16'd1927, 16'd0, 16'd0, 13'd8191, 16'd0, 0, 13'd8191);
    check();
    // MODMUL immediate: 300*300 mod 997 = 270
    drive("modmul_imm", 0, 1, 0, 0, 2'b10, 16'd300, 16'd0, 16'd997, 16'd300, 13'd8191, 16'd270, 0, 13'd8191);
    check();
    // Full 32-bit product: 65535^2 mod 65521 = 14^2 = 196
    drive("modmul_big", 0, 1, 0, 0, 2'b10, 16'hFFFF, 16'd0, 16'd65521, 16'hFFFF, 13'd8191, 16'd196, 0, 13'd8191);
    check();
    // ADD wrap-around discards carry
    drive("add_wrap", 0, 1, 0, 0, 2'b00, 16'hFFFF, 16'd0, 16'd0, 16'd1, 13'd8191, 16'd0, 0, 13'd8191);
    check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
